// File: rtl/wb_sched_pkg.sv
// Shared types and defaults for the writeback slot scheduler.
package wb_sched_pkg;

    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned TAG_W_DEF = 5;

    // Latency field width: must hold the values 0..depth.
    function automatic int unsigned lat_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // One reservation slot; tags wider than TAG_W_DEF need this default raised.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
    } slot_t;

endpackage

// File: rtl/wb_slot_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. The pointer flips only when both
// requests are present, so uncontested grants leave the priority unchanged.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer update.
    always_comb begin
        gnt_c = req;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            gnt_c = ptr_q ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
        end
    end

    // Pointer register; reset favours requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_slot_sched.sv
// wb_slot_sched: reserves the single register-file writeback slot L cycles
// ahead for two fixed-latency requesters and emits wb_valid/wb_tag when the
// reservation matures.
// Optional conflict-stall counter enabled by defining WB_SCHED_STATS_EN.
//
// Stored table entry i reserves the writeback of cycle now+1+i. Only DEPTH-1
// entries need storage: the furthest slot (now+DEPTH) can only be claimed by
// a grant made this cycle, and a latency-1 grant goes straight into the
// registered writeback output.
module wb_slot_sched
    import wb_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned LAT_W = lat_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [LAT_W-1:0] req0_lat,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [LAT_W-1:0] req1_lat,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    input  logic             flush,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic             busy,
    output logic             lat_err,
    output logic [31:0]      stall_cnt
);

    localparam int unsigned NSLOT = DEPTH - 1;

    slot_t [NSLOT-1:0] tab_q;
    slot_t [NSLOT-1:0] tab_d;
    logic              wb_valid_q;
    logic              wb_valid_d;
    logic [TAG_W-1:0]  wb_tag_q;
    logic [TAG_W-1:0]  wb_tag_d;
    logic              lat_err_q;
    logic              lat_err_d;

    logic       legal0;
    logic       legal1;
    logic       hit0;
    logic       hit1;
    logic       elig0;
    logic       elig1;
    logic       same_slot;
    logic       gnt0;
    logic       gnt1;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    // Latency legality, target-slot lookup and per-requester eligibility.
    always_comb begin
        legal0 = (req0_lat != '0) && (32'(req0_lat) <= DEPTH);
        legal1 = (req1_lat != '0) && (32'(req1_lat) <= DEPTH);
        hit0   = 1'b0;
        hit1   = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (32'(req0_lat) == i + 1) hit0 = tab_q[i].valid;
            if (32'(req1_lat) == i + 1) hit1 = tab_q[i].valid;
        end
        elig0     = req0_valid && legal0 && !hit0 && !flush;
        elig1     = req1_valid && legal1 && !hit1 && !flush;
        same_slot = (req0_lat == req1_lat);
        arb_req   = same_slot ? {elig1, elig0} : 2'b00;
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .gnt_c (arb_gnt)
    );

    // Final grants: the arbiter only decides same-slot races.
    always_comb begin
        gnt0 = same_slot ? arb_gnt[0] : elig0;
        gnt1 = same_slot ? arb_gnt[1] : elig1;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Any reservation still waiting in the table.
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            busy = busy | tab_q[i].valid;
        end
    end

    // Table shift, grant insertion, writeback and flush.
    always_comb begin
        tab_d      = '0;
        wb_valid_d = tab_q[0].valid;
        wb_tag_d   = tab_q[0].valid ? TAG_W'(tab_q[0].tag) : wb_tag_q;
        lat_err_d  = lat_err_q | (req0_valid & ~legal0) | (req1_valid & ~legal1);

        for (int unsigned i = 0; i + 1 < NSLOT; i++) begin
            tab_d[i] = tab_q[i + 1];
        end
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (gnt0 && (32'(req0_lat) == i + 2)) begin
                tab_d[i] = '{valid: 1'b1, tag: TAG_W_DEF'(req0_tag)};
            end
            if (gnt1 && (32'(req1_lat) == i + 2)) begin
                tab_d[i] = '{valid: 1'b1, tag: TAG_W_DEF'(req1_tag)};
            end
        end

        if (gnt0 && (req0_lat == LAT_W'(1))) begin
            wb_valid_d = 1'b1;
            wb_tag_d   = req0_tag;
        end
        if (gnt1 && (req1_lat == LAT_W'(1))) begin
            wb_valid_d = 1'b1;
            wb_tag_d   = req1_tag;
        end

        // The slot writing back this cycle is already in the output register.
        if (flush) begin
            tab_d      = '0;
            wb_valid_d = 1'b0;
            wb_tag_d   = wb_tag_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tab_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            lat_err_q  <= 1'b0;
        end else begin
            tab_q      <= tab_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            lat_err_q  <= lat_err_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_tag   = wb_tag_q;
    assign lat_err  = lat_err_q;

`ifdef WB_SCHED_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic        stalled;

    // Saturating count of cycles where a legal request was held off.
    always_comb begin
        stalled     = (req0_valid && legal0 && !gnt0) || (req1_valid && legal1 && !gnt1);
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_slot_sched.sv
// Bench for wb_slot_sched: directed scenarios followed by random traffic,
// all checked against a reservation map keyed by absolute cycle number.
module tb_wb_slot_sched;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned LAT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic [LAT_W-1:0] req0_lat;
    logic [TAG_W-1:0] req0_tag;
    logic             req0_ready;
    logic             req1_valid;
    logic [LAT_W-1:0] req1_lat;
    logic [TAG_W-1:0] req1_tag;
    logic             req1_ready;
    logic             flush;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic             busy;
    logic             lat_err;
    logic [31:0]      stall_cnt;

    wb_slot_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LAT_W(LAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_lat   (req0_lat),
        .req0_tag   (req0_tag),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_lat   (req1_lat),
        .req1_tag   (req1_tag),
        .req1_ready (req1_ready),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_tag     (wb_tag),
        .busy       (busy),
        .lat_err    (lat_err),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: absolute writeback cycle -> tag reserved for it.
    logic [TAG_W-1:0] resv [int];
    bit               rr_fav1;
    bit               exp_err;
    logic [31:0]      exp_stall;
    logic [TAG_W-1:0] last_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic reset_model();
        resv.delete();
        rr_fav1   = 1'b0;
        exp_err   = 1'b0;
        exp_stall = 32'd0;
        last_tag  = '0;
    endtask

    // One clock cycle: check this cycle's outputs, apply inputs, check ready,
    // then advance the model across the clock edge.
    task automatic cycle(input bit v0, input int l0, input int t0,
                         input bit v1, input int l1, input int t1,
                         input bit fl, input bit rs);
        bit wbv, lg0, lg1, e0, e1, g0, g1, contest;
        wbv = resv.exists(cyc);
        if (wbv) begin
            last_tag = resv[cyc];
            resv.delete(cyc);
        end
        chk("wb_valid",  32'(wb_valid), 32'(wbv));
        chk("wb_tag",    32'(wb_tag),   32'(last_tag));
        chk("busy",      32'(busy),     32'(resv.num() != 0));
        chk("lat_err",   32'(lat_err),  32'(exp_err));
        chk("stall_cnt", stall_cnt,     exp_stall);

        req0_valid = v0;
        req0_lat   = LAT_W'(l0);
        req0_tag   = TAG_W'(t0);
        req1_valid = v1;
        req1_lat   = LAT_W'(l1);
        req1_tag   = TAG_W'(t1);
        flush      = fl;
        rst        = rs;
        #1;

        lg0     = (l0 >= 1) && (l0 <= int'(DEPTH));
        lg1     = (l1 >= 1) && (l1 <= int'(DEPTH));
        e0      = v0 && lg0 && !fl && !resv.exists(cyc + l0);
        e1      = v1 && lg1 && !fl && !resv.exists(cyc + l1);
        contest = e0 && e1 && (l0 == l1);
        g0      = contest ? !rr_fav1 : e0;
        g1      = contest ?  rr_fav1 : e1;
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));

        @(posedge clk);
        if (rs) begin
            reset_model();
        end else begin
            if (g0) resv[cyc + l0] = TAG_W'(t0);
            if (g1) resv[cyc + l1] = TAG_W'(t1);
            if (fl) resv.delete();
            if (contest) rr_fav1 = !rr_fav1;
            if ((v0 && !lg0) || (v1 && !lg1)) exp_err = 1'b1;
`ifdef WB_SCHED_STATS_EN
            if (((v0 && lg0 && !g0) || (v1 && lg1 && !g1)) && (exp_stall != 32'hFFFF_FFFF))
                exp_stall = exp_stall + 32'd1;
`endif
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_lat   = '0;
        req0_tag   = '0;
        req1_valid = 1'b0;
        req1_lat   = '0;
        req1_tag   = '0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        cyc = 0;

        // Reset values, then a single latency-3 op.
        idle(2);
        cycle(1, 3, 7, 0, 0, 0, 0, 0);
        idle(5);

        // Slot conflict: lat 4 at t, lat 2 at t+2 blocked, granted at t+3.
        cycle(1, 4, 3, 0, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 1, 2, 9, 0, 0);
        cycle(0, 0, 0, 1, 2, 9, 0, 0);
        idle(6);

        // Same-slot race for three cycles.
        cycle(1, 2, 1, 1, 2, 2, 0, 0);
        cycle(1, 2, 3, 1, 2, 4, 0, 0);
        cycle(1, 2, 5, 1, 2, 6, 0, 0);
        idle(5);

        // Parallel grant with different latencies, including the maximum.
        cycle(1, 1, 4, 1, 5, 5, 0, 0);
        idle(3);
        cycle(1, 8, 20, 1, 7, 21, 0, 0);
        idle(9);

        // Flush kills an outstanding reservation and blocks same-cycle grants.
        cycle(1, 6, 10, 0, 0, 0, 0, 0);
        idle(1);
        cycle(1, 1, 11, 0, 0, 0, 1, 0);
        idle(6);

        // Flush while a slot matures in the same cycle.
        cycle(1, 2, 14, 0, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Illegal latencies, then reset with ops outstanding.
        cycle(1, 0, 12, 0, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 1, 12, 13, 0, 0);
        cycle(1, 5, 13, 1, 7, 14, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        idle(8);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 99) < 70, int'($urandom_range(0, 9)), int'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < 70, int'($urandom_range(0, 9)), int'($urandom_range(0, 31)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0);
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_slot_sched.md
Name: wb_slot_sched

Overview:
- Writeback-port scheduler for the fixed-latency execution pipes built on the shift-register delay lines.
- Two requesters (e.g. ALU and MUL issue) request an op with a fixed latency; the block reserves the single register-file writeback slot that many cycles ahead.
- Grants only when that slot is free, round-robin between requesters on a same-slot conflict.
- Emits the writeback valid/tag when the slot matures; this sits between issue and the delay-line datapaths.

Parameters:
- DEPTH, 8, maximum op latency in cycles (number of reservation slots); legal latencies 1..DEPTH.
- TAG_W, 5, width of the destination tag (rd index) carried to writeback.
- LAT_W, $clog2(DEPTH+1), width of the latency fields (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 presents an op.
- req0_lat  in  LAT_W  latency of requester 0's op.
- req0_tag  in  TAG_W  destination tag of requester 0's op.
- req0_ready  out  1  grant; the op transfers when valid and ready are both high.
- req1_valid, req1_lat, req1_tag, req1_ready  as for requester 0.
- flush  in  1  kill all outstanding reservations (branch mispredict / trap).
- wb_valid  out  1  writeback occurs this cycle (registered).
- wb_tag  out  TAG_W  tag of the maturing op (registered).
- busy  out  1  any reservation outstanding (combinational OR of the table).
- lat_err  out  1  sticky: a valid request carried an illegal latency.
- stall_cnt  out  32  conflict-stall counter (see Optional Feature).

Behaviour:
- Reservation table: DEPTH entries of {valid, tag}; it shifts one slot toward maturity every cycle.
- Timing: an op granted in cycle t drives wb_valid=1 with its tag during cycle t+L. L=1 means the next cycle.
- Grant rule: reqN_ready=1 iff reqN_valid, L is legal, slot t+L is not reserved, flush=0, and reqN wins arbitration if both target the same slot.
- ready is combinational from the current inputs and the table state; a requester may hold valid across stalls.
- Different latencies, both slots free: both granted in the same cycle.
- Same latency, slot free: only the round-robin winner is granted. The rr pointer flips to the other requester after each contested grant; uncontested grants leave it unchanged.
- Illegal latency (0 or >DEPTH): ready=0 forever for that request; lat_err set on the next edge and held until rst.
- wb_valid/wb_tag: when wb_valid=0, wb_tag holds its last value.
- Flush in cycle t:
  - no grants in cycle t;
  - all reservations cleared at the edge ending t;
  - wb_valid=0 from cycle t+1 until a new op matures.
  - A slot maturing in cycle t itself still writes back.
- Simultaneous flush and rst: rst dominates (identical result).
- Reset values: table empty, wb_valid=0, wb_tag=0, rr pointer favours req0, lat_err=0, stall_cnt=0, busy=0.
- Reset mid-operation discards all outstanding ops.

Optional Feature:
- Macro WB_SCHED_STATS_EN.
- When defined: stall_cnt increments once per cycle in which some reqN_valid=1 with a legal latency and that requester's reqN_ready=0. It saturates at 32'hFFFF_FFFF and clears on rst only.
- When undefined: stall_cnt is constant 0 and no counter logic is built.

Decomposition:
- Package wb_sched_pkg: DEPTH default, TAG_W default, LAT_W function, and the slot entry struct {valid, tag}.
- One sub-module, rr_arb2: 2-way round-robin arbiter with a pointer register.
- The table and grant logic stay in wb_slot_sched.

Test Plan:
- Single op: req0 lat=3 tag=7 granted at cycle 10 -> wb_valid=1, wb_tag=7 at cycle 13 only; busy=1 during cycles 11–12.
- Conflict: req0 lat=4 at t=0, then req1 lat=2 at t=2 -> req1_ready=0 at t=2 (slot 4 taken). req1 granted at t=3 -> writebacks at t=4 (tag0) and t=5 (tag1).
- Same-slot race: both request lat=2 for 3 consecutive cycles with distinct tags -> grants alternate req0, req1, req0. With the feature on, stall_cnt=3.
- Parallel grant: req0 lat=1, req1 lat=5 in the same cycle -> both ready=1; wb at t+1 and t+5.
- Flush: grant lat=6 at t=0, flush at t=2 -> no wb_valid at t=6, busy=0 from t=3. A lat=1 request at t=2 gets ready=0.
- Illegal and reset: req0 lat=0 -> ready=0, lat_err=1 next cycle. rst with ops outstanding -> all outputs return to reset values next cycle; lat_err clears.
